burst_mem_ctrl: RTL
===================

Name: burst_mem_ctrl

Overview:
Multi-cell burst memory for the coprocessor. Each access transfers BLOCKS consecutive cells of CELL_WIDTH bits over a valid/ready request channel and a valid/ready response channel. It adds three features: a synthesizable post-reset clear sweep, per-cell write masking, and selectable wrap-around or error on out-of-range bursts. It sits between the coprocessor control FSM and the matrix datapath as the operand/result store.

Parameters:
SIZE, 1024, number of cells; must equal 2**LOG_SIZE and be a multiple of BLOCKS
BLOCKS, 4, cells per burst (≥1)
LOG_SIZE, 10, address width
CELL_WIDTH, 32, bits per cell
WRAP, 1, 1 = burst addresses wrap modulo SIZE; 0 = out-of-range burst returns an error and has no side effect
WIDTH (localparam), BLOCKS*CELL_WIDTH, bus width

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous, active-low reset
in_req_valid  input  1  request present
out_req_ready  output  1  request accepted when valid&&ready at a rising edge
in_req_write  input  1  1 = write, 0 = read
in_address  input  LOG_SIZE  base cell address
in_data  input  WIDTH  write data; cell i = bits [i*CELL_WIDTH +: CELL_WIDTH]
in_mask  input  BLOCKS  per-cell write enable; bit i controls cell i; ignored on reads
out_rsp_valid  output  1  response present
in_rsp_ready  input  1  response consumed when valid&&ready at a rising edge
out_data  output  WIDTH  read data, same cell packing as in_data
out_error  output  1  response flags a rejected out-of-range burst (WRAP=0 only)
out_busy  output  1  high during the clear sweep

Behaviour:
- FSM states: CLEAR, IDLE, RESP.
- Reset (in_reset=0, asynchronous):
  - state→CLEAR, clear pointer→0.
  - out_req_ready=0, out_rsp_valid=0, out_data=0, out_error=0, out_busy=1.
- CLEAR:
  - Each rising edge writes 0 to cells ptr..ptr+BLOCKS-1; ptr += BLOCKS.
  - After SIZE/BLOCKS edges: state→IDLE, out_busy=0, out_req_ready=1.
  - Requests are ignored in CLEAR (ready=0).
- IDLE:
  - out_req_ready=1.
  - On accept: cell i address = (in_address+i) mod SIZE.
  - Range check: if WRAP=0 and in_address+BLOCKS-1 > SIZE-1, the burst is out of range. Register the response with out_error=1 and out_data=0; memory is unchanged.
  - Valid write: for each i with in_mask[i]=1, the cell is updated at the accept edge. Response has out_data=0, out_error=0.
  - Valid read: out_data cell i = memory contents before the accept edge. Response has out_error=0.
  - State→RESP; out_req_ready drops to 0 after the accept edge.
- RESP:
  - out_rsp_valid=1; out_data and out_error are held stable until the handshake.
  - On in_rsp_ready=1 at a rising edge: out_rsp_valid→0, out_data→0, out_error→0, state→IDLE.
- Latency and throughput:
  - Response is visible the cycle after accept.
  - Peak rate is one request per 2 cycles; there is no overlap of request and response.
- Exactly one response per accepted request. Mask=0 write still produces a response.
- The asynchronous reset mid-RESP or mid-CLEAR aborts immediately and restarts the clear sweep. Memory contents are undefined until the sweep completes.
- All address arithmetic is done in LOG_SIZE+1 bits for the range check and truncated to LOG_SIZE for wrap.

Test Plan (SIZE=1024, BLOCKS=4, CELL_WIDTH=32, WRAP=1 unless stated):
1. Pulse in_reset low, release, and count cycles → out_busy=1 and ready=0 for exactly 256 edges, then ready=1. Read addr 0 → out_data=0 and out_error=0, one cycle after accept.
2. Write addr 8, data {44444444,33333333,22222222,11111111}, mask 1111, then read addr 8 → out_data=44444444_33333333_22222222_11111111. Write response out_data=0.
3. Write addr 8, data all FFFFFFFF, mask 0101, then read addr 8 → 44444444_FFFFFFFF_22222222_FFFFFFFF.
4. Wrap: write addr 1022, data {D,C,B,A} cells 3..0 → read addr 1020 upper half {B,A}; read addr 0 low cells {D,C}. With a WRAP=0 instance, the same write → out_error=1, and read 1020 shows no change.
5. Backpressure: read with in_rsp_ready=0 for 5 cycles → out_rsp_valid=1 with out_data stable and out_req_ready=0 throughout. Raise ready → valid drops next edge and ready returns to 1.
6. Assert in_reset while out_rsp_valid=1 → valid, data and ready go to 0 immediately (no clock) and busy=1. After the 256-cycle sweep, read addr 8 → 0.

Source files
------------

// File: rtl/burst_mem_ctrl_if.sv
// Request/response channel of the burst memory: one valid/ready request channel
// carrying a BLOCKS-cell burst and one valid/ready response channel.
interface burst_mem_ctrl_if #(
  parameter int BLOCKS     = 4,
  parameter int LOG_SIZE   = 10,
  parameter int CELL_WIDTH = 32
);
  localparam int WIDTH = BLOCKS * CELL_WIDTH;

  logic                in_req_valid;
  logic                out_req_ready;
  logic                in_req_write;
  logic [LOG_SIZE-1:0] in_address;
  logic [WIDTH-1:0]    in_data;
  logic [BLOCKS-1:0]   in_mask;
  logic                out_rsp_valid;
  logic                in_rsp_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_error;
  logic                out_busy;

  modport master (
    output in_req_valid, in_req_write, in_address, in_data, in_mask, in_rsp_ready,
    input  out_req_ready, out_rsp_valid, out_data, out_error, out_busy
  );

  modport slave (
    input  in_req_valid, in_req_write, in_address, in_data, in_mask, in_rsp_ready,
    output out_req_ready, out_rsp_valid, out_data, out_error, out_busy
  );
endinterface

// File: rtl/burst_mem_ctrl.sv
// Burst operand/result store: post-reset clear sweep, per-cell write masking and
// wrap-around or error handling for bursts that run past the top cell.
module burst_mem_ctrl #(
  parameter int SIZE       = 1024,
  parameter int BLOCKS     = 4,
  parameter int LOG_SIZE   = 10,
  parameter int CELL_WIDTH = 32,
  parameter int WRAP       = 1
) (
  input  logic             in_clk,
  input  logic             in_reset,
  burst_mem_ctrl_if.slave  bus
);
  localparam int WIDTH = BLOCKS * CELL_WIDTH;
  localparam logic [LOG_SIZE:0]   SPAN     = (LOG_SIZE+1)'(BLOCKS - 1);
  localparam logic [LOG_SIZE:0]   TOP_ADDR = (LOG_SIZE+1)'(SIZE - 1);
  localparam logic [LOG_SIZE-1:0] LAST_PTR = LOG_SIZE'(SIZE - BLOCKS);
  localparam logic [LOG_SIZE-1:0] STEP     = LOG_SIZE'(BLOCKS);

  typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_e;

  state_e              state_q, state_d;
  logic [LOG_SIZE-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                err_q, err_d;

  logic [CELL_WIDTH-1:0] mem_q [SIZE];

  logic [LOG_SIZE-1:0]   cell_addr [BLOCKS];
  logic [LOG_SIZE:0]     last_addr;
  logic                  out_of_range;
  logic                  accept;
  logic [BLOCKS-1:0]     we;
  logic [LOG_SIZE-1:0]   wr_addr [BLOCKS];
  logic [CELL_WIDTH-1:0] wr_data [BLOCKS];

  // Burst addressing: cell addresses wrap by truncation, the range check uses one extra bit.
  always_comb begin
    for (int i = 0; i < BLOCKS; i++) begin
      cell_addr[i] = bus.in_address + LOG_SIZE'(i);
    end
    last_addr    = {1'b0, bus.in_address} + SPAN;
    out_of_range = (WRAP == 0) && (last_addr > TOP_ADDR);
    accept       = (state_q == IDLE) && bus.in_req_valid;
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    err_d   = err_q;
    we      = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      wr_addr[i] = cell_addr[i];
      wr_data[i] = bus.in_data[i*CELL_WIDTH +: CELL_WIDTH];
    end

    unique case (state_q)
      CLEAR: begin
        we = '1;
        for (int i = 0; i < BLOCKS; i++) begin
          wr_addr[i] = ptr_q + LOG_SIZE'(i);
          wr_data[i] = '0;
        end
        ptr_d = ptr_q + STEP;
        if (ptr_q == LAST_PTR) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          err_d   = out_of_range;
          data_d  = '0;
          // A rejected burst must leave memory untouched and return no data.
          if (!out_of_range) begin
            if (bus.in_req_write) begin
              we = bus.in_mask;
            end else begin
              for (int i = 0; i < BLOCKS; i++) begin
                data_d[i*CELL_WIDTH +: CELL_WIDTH] = mem_q[cell_addr[i]];
              end
            end
          end
        end
      end
      RESP: begin
        if (bus.in_rsp_ready) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Storage carries no reset; the clear sweep provides the defined contents.
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < BLOCKS; i++) begin
      if (we[i]) mem_q[wr_addr[i]] <= wr_data[i];
    end
  end

  assign bus.out_req_ready = (state_q == IDLE);
  assign bus.out_rsp_valid = (state_q == RESP);
  assign bus.out_busy      = (state_q == CLEAR);
  assign bus.out_data      = data_q;
  assign bus.out_error     = err_q;
endmodule
